mult_pipe: RTL and testbench
============================

MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; legal values are powers of 2 from 1 to 2*XLEN.
REQ-003 SHALL have parameter TAG_W, default 6, destination physical-register tag width.
REQ-004 SHALL have parameter BMASK_W, default 4, branch-mask width.
REQ-005 SHALL have ports: clock  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; in_func in MULT_FUNC; in_rs1/in_rs2 in XLEN; in_tag in TAG_W; in_bmask in BMASK_W.
REQ-007 SHALL have ports: squash_valid in 1; squash_bmask in BMASK_W (kill set); resolve_valid in 1; resolve_bmask in BMASK_W (bits to clear).
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_result out XLEN; out_tag out TAG_W; out_bmask out BMASK_W; busy out 1 (any stage valid).

Function
REQ-009 SHALL accept an operation on a clock edge where in_valid && in_ready && !(squash_valid && (in_bmask & squash_bmask) != 0).
REQ-010 SHALL extend operands to 2*XLEN: MUL and MULH sign-extend both; MULHSU sign-extends rs1 and zero-extends rs2; MULHU zero-extends both.
REQ-011 SHALL have each stage add (multiplier low 2*XLEN/STAGES bits x multiplicand) to the running sum, shift the multiplier right and the multiplicand left by 2*XLEN/STAGES.
REQ-012 SHALL drive out_result as product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] otherwise; the func, tag and bmask SHALL travel with the data.
REQ-013 SHALL present the result with out_valid exactly STAGES cycles after acceptance when nothing stalls.
REQ-014 SHALL hold out_valid, out_result, out_tag and out_bmask stable while out_valid && !out_ready.
REQ-015 SHALL, without the collapse feature, freeze all stages while out_valid && !out_ready, and drive in_ready = !(out_valid && !out_ready).
REQ-016 SHALL preserve issue order; there SHALL be no reordering or duplication.
REQ-017 SHALL, when squash_valid, clear at the next edge the valid bit of every stage whose bmask & squash_bmask != 0, including frozen stages.
REQ-018 SHALL gate out_valid low combinationally in the same cycle as a squash that hits the last stage.
REQ-019 SHALL, when resolve_valid, clear the resolve_bmask bits in every stage's bmask and in the incoming in_bmask at the next edge, and SHALL reflect this combinationally on out_bmask in the same cycle.
REQ-020 SHALL give squash priority over resolve when both name the same bit in the same cycle.
REQ-021 SHALL allow an output handshake and a squash of the same entry in the same cycle; this counts as no transfer.
REQ-022 SHALL sustain one acceptance per cycle when out_ready stays high.

Reset
REQ-023 SHALL, on reset, clear all stage valid bits, so out_valid=0 and busy=0.
REQ-024 SHALL drive in_ready=1 in the first cycle after reset.
REQ-025 SHALL reset data, tag and bmask registers to 0.
REQ-026 SHALL abandon in-flight operations on reset asserted mid-operation, with no output produced for them.

Configuration
REQ-027 SHALL, with MULT_PIPE_COLLAPSE_EN defined, advance stage i when it is empty or when stage i+1 is empty or advancing; the last stage advances on !out_valid || out_ready.
REQ-028 SHALL, with MULT_PIPE_COLLAPSE_EN defined, drive in_ready = stage 0 empty or advancing, so bubbles are squeezed out behind a stalled output.
REQ-029 SHALL, without MULT_PIPE_COLLAPSE_EN, use the global freeze of REQ-015; latency and results are otherwise identical.

Structure
REQ-030 SHALL take the MULT_FUNC enum (M_MUL, M_MULH, M_MULHSU, M_MULHU) and the tag/bmask widths from the shared package sys_defs.
REQ-031 SHALL implement one stage per instance of a sub-module mult_pipe_stage (partial product, shift, valid/tag/bmask registers, squash/resolve logic), generated STAGES times.
REQ-032 SHALL keep handshake and stall control in the top-level module.

Verification
REQ-033 SHALL cover MUL rs1=7, rs2=-3 (XLEN=32) -> out_result=0xFFFFFFEB after 4 cycles, tag preserved.
REQ-034 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
REQ-035 SHALL cover issuing 4 back-to-back ops with out_ready=0 for 6 cycles -> out_valid holds the first op, outputs stable, and in_ready=0 once full; then out_ready=1 -> 4 results in order, one per cycle.
REQ-036 SHALL cover entries with bmask 0b0010 and 0b0100 in flight, squash_bmask=0b0010 -> only the 0b0010 entry disappears and busy stays 1.
REQ-037 SHALL cover resolve_bmask=0b0100 in the same cycle as squash_bmask=0b0100 -> the entry is killed; on a later op, resolve alone -> out_bmask bit 2 is clear.
REQ-038 SHALL cover, with MULT_PIPE_COLLAPSE_EN: an op issued, a 2-cycle gap, a second op, and out_ready=0 -> in_ready stays 1 until all stages are full; without the macro, in_ready=0 from the first stalled cycle.

Source files
------------

// File: rtl/sys_defs.sv
// Shared core definitions: multiplier function encoding and default
// physical-register tag / branch-mask widths used by execution units.
// Combinational only; no ports.
package sys_defs;

  typedef enum logic [1:0] {
    M_MUL    = 2'd0,
    M_MULH   = 2'd1,
    M_MULHSU = 2'd2,
    M_MULHU  = 2'd3
  } MULT_FUNC;

  localparam int TAG_W_DEF   = 6;
  localparam int BMASK_W_DEF = 4;

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline stage: adds (low chunk of multiplier x multiplicand)
// to the running sum and shifts both operands by one chunk; 1 cycle latency.
// Backpressure: when adv=0 the stage holds, but squash/resolve still apply.
// Ports: clock/reset; adv (load from previous stage); prev_* (previous stage
// state); squash_*/resolve_* (branch kill / clear); valid/func/tag/bmask/
// mplier/mcand/sum (registered stage state).
module mult_pipe_stage
  import sys_defs::*;
#(
  parameter int XLEN    = 32,
  parameter int STAGES  = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int BMASK_W = BMASK_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 adv,
  input  logic                 prev_valid,
  input  MULT_FUNC             prev_func,
  input  logic [TAG_W-1:0]     prev_tag,
  input  logic [BMASK_W-1:0]   prev_bmask,
  input  logic [2*XLEN-1:0]    prev_mplier,
  input  logic [2*XLEN-1:0]    prev_mcand,
  input  logic [2*XLEN-1:0]    prev_sum,
  input  logic                 squash_valid,
  input  logic [BMASK_W-1:0]   squash_bmask,
  input  logic                 resolve_valid,
  input  logic [BMASK_W-1:0]   resolve_bmask,
  output logic                 valid,
  output MULT_FUNC             func,
  output logic [TAG_W-1:0]     tag,
  output logic [BMASK_W-1:0]   bmask,
  output logic [2*XLEN-1:0]    mplier,
  output logic [2*XLEN-1:0]    mcand,
  output logic [2*XLEN-1:0]    sum
);

  localparam int W    = 2 * XLEN;
  localparam int CW   = W / STAGES;
  localparam int DROP = W - CW;

  logic               valid_q, valid_d;
  MULT_FUNC           func_q, func_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [BMASK_W-1:0] bmask_q, bmask_d;
  logic [W-1:0]       mplier_q, mplier_d;
  logic [W-1:0]       mcand_q, mcand_d;
  logic [W-1:0]       sum_q, sum_d;

  logic [W-1:0]       mpl_chunk;
  logic [BMASK_W-1:0] rmask;
  logic               kill_prev, kill_own;

  always_comb begin
    // Isolate the low CW bits of the multiplier without a zero-width replicate.
    mpl_chunk = (prev_mplier << DROP) >> DROP;
    rmask     = resolve_valid ? resolve_bmask : '0;
    // Squash is judged on the bmask before resolve clears bits, so it wins.
    kill_prev = squash_valid && ((prev_bmask & squash_bmask) != '0);
    kill_own  = squash_valid && ((bmask_q & squash_bmask) != '0);

    valid_d  = valid_q && !kill_own;
    func_d   = func_q;
    tag_d    = tag_q;
    bmask_d  = bmask_q & ~rmask;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    sum_d    = sum_q;

    if (adv) begin
      valid_d  = prev_valid && !kill_prev;
      func_d   = prev_func;
      tag_d    = prev_tag;
      bmask_d  = prev_bmask & ~rmask;
      mplier_d = prev_mplier >> CW;
      mcand_d  = prev_mcand << CW;
      sum_d    = prev_sum + mpl_chunk * prev_mcand;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      func_q   <= M_MUL;
      tag_q    <= '0;
      bmask_q  <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      sum_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      func_q   <= func_d;
      tag_q    <= tag_d;
      bmask_q  <= bmask_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      sum_q    <= sum_d;
    end
  end

  assign valid  = valid_q;
  assign func   = func_q;
  assign tag    = tag_q;
  assign bmask  = bmask_q;
  assign mplier = mplier_q;
  assign mcand  = mcand_q;
  assign sum    = sum_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU) with branch-
// mask squash/resolve; result appears STAGES cycles after the accept cycle.
// Backpressure: default build freezes the whole pipe on out_valid&&!out_ready;
// with MULT_PIPE_COLLAPSE_EN defined, bubbles collapse behind a stalled output.
// Ports: clock, reset (sync, active-high); in_* request with valid/ready;
// squash_*/resolve_* branch kill/clear; out_* result with valid/ready; busy.
module mult_pipe
  import sys_defs::*;
#(
  parameter int XLEN    = 32,
  parameter int STAGES  = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int BMASK_W = BMASK_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  MULT_FUNC           in_func,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [BMASK_W-1:0] in_bmask,
  input  logic               squash_valid,
  input  logic [BMASK_W-1:0] squash_bmask,
  input  logic               resolve_valid,
  input  logic [BMASK_W-1:0] resolve_bmask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic [BMASK_W-1:0] out_bmask,
  output logic               busy
);

  localparam int W    = 2 * XLEN;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]  vld_a;
  MULT_FUNC           func_a   [STAGES];
  logic [TAG_W-1:0]   tag_a    [STAGES];
  logic [BMASK_W-1:0] bmask_a  [STAGES];
  logic [W-1:0]       mplier_a [STAGES];
  logic [W-1:0]       mcand_a  [STAGES];
  logic [W-1:0]       sum_a    [STAGES];

  logic [STAGES-1:0]  adv;
  logic [W-1:0]       rs1_ext, rs2_ext;
  logic               s0_valid;
  logic               hit_last;

  always_comb begin
    rs1_ext = {{XLEN{1'b0}}, in_rs1};
    rs2_ext = {{XLEN{1'b0}}, in_rs2};
    case (in_func)
      M_MUL, M_MULH: begin
        rs1_ext = {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
        rs2_ext = {{XLEN{in_rs2[XLEN-1]}}, in_rs2};
      end
      M_MULHSU: rs1_ext = {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
      default: ;
    endcase
  end

  // A squash hitting the last stage must suppress the output this cycle.
  assign hit_last  = squash_valid && ((bmask_a[LAST] & squash_bmask) != '0);
  assign out_valid = vld_a[LAST] && !hit_last;
  assign out_tag   = tag_a[LAST];
  assign out_bmask = bmask_a[LAST] & ~(resolve_valid ? resolve_bmask : '0);
  assign out_result = (func_a[LAST] == M_MUL) ? sum_a[LAST][XLEN-1:0]
                                              : sum_a[LAST][W-1:XLEN];
  assign busy = |vld_a;

`ifdef MULT_PIPE_COLLAPSE_EN
  logic last_adv;
  assign last_adv = !out_valid || out_ready;
  // Stage i may move when any stage from i to the end has a hole, or the
  // output drains: the unrolled form of "i+1 empty or advancing".
  for (genvar i = 0; i < STAGES; i++) begin : g_adv
    assign adv[i] = !(&vld_a[LAST:i]) || last_adv;
  end
  assign in_ready = adv[0];
`else
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign adv      = {STAGES{!stall}};
  assign in_ready = !stall;
`endif

  // Squash of the incoming op is applied inside stage 0.
  assign s0_valid = in_valid && in_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      mult_pipe_stage #(
        .XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .BMASK_W(BMASK_W)
      ) u_stage (
        .clock        (clock),
        .reset        (reset),
        .adv          (adv[i]),
        .prev_valid   (s0_valid),
        .prev_func    (in_func),
        .prev_tag     (in_tag),
        .prev_bmask   (in_bmask),
        .prev_mplier  (rs2_ext),
        .prev_mcand   (rs1_ext),
        .prev_sum     ({W{1'b0}}),
        .squash_valid (squash_valid),
        .squash_bmask (squash_bmask),
        .resolve_valid(resolve_valid),
        .resolve_bmask(resolve_bmask),
        .valid        (vld_a[i]),
        .func         (func_a[i]),
        .tag          (tag_a[i]),
        .bmask        (bmask_a[i]),
        .mplier       (mplier_a[i]),
        .mcand        (mcand_a[i]),
        .sum          (sum_a[i])
      );
    end else begin : g_rest
      mult_pipe_stage #(
        .XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .BMASK_W(BMASK_W)
      ) u_stage (
        .clock        (clock),
        .reset        (reset),
        .adv          (adv[i]),
        .prev_valid   (vld_a[i-1]),
        .prev_func    (func_a[i-1]),
        .prev_tag     (tag_a[i-1]),
        .prev_bmask   (bmask_a[i-1]),
        .prev_mplier  (mplier_a[i-1]),
        .prev_mcand   (mcand_a[i-1]),
        .prev_sum     (sum_a[i-1]),
        .squash_valid (squash_valid),
        .squash_bmask (squash_bmask),
        .resolve_valid(resolve_valid),
        .resolve_bmask(resolve_bmask),
        .valid        (vld_a[i]),
        .func         (func_a[i]),
        .tag          (tag_a[i]),
        .bmask        (bmask_a[i]),
        .mplier       (mplier_a[i]),
        .mcand        (mcand_a[i]),
        .sum          (sum_a[i])
      );
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe (XLEN=32, STAGES=4): arithmetic, latency,
// stall/ordering, squash/resolve, reset abandonment, bubble collapse.
module tb_mult_pipe;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  MULT_FUNC    in_func;
  logic [31:0] in_rs1, in_rs2;
  logic [5:0]  in_tag;
  logic [3:0]  in_bmask;
  logic        squash_valid;
  logic [3:0]  squash_bmask;
  logic        resolve_valid;
  logic [3:0]  resolve_bmask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic [3:0]  out_bmask;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mult_pipe #(.XLEN(32), .STAGES(4), .TAG_W(6), .BMASK_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_func      (in_func),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_tag       (in_tag),
    .in_bmask     (in_bmask),
    .squash_valid (squash_valid),
    .squash_bmask (squash_bmask),
    .resolve_valid(resolve_valid),
    .resolve_bmask(resolve_bmask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_bmask    (out_bmask),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input MULT_FUNC f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, input logic [3:0] m);
    in_valid = 1'b1;
    in_func  = f;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = t;
    in_bmask = m;
  endtask

  // Single op with out_ready high: absent after 3 edges, present after 4.
  task automatic run_one(input string nm, input MULT_FUNC f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(f, a, b, 6'd5, 4'b0000);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({nm, "_early"}, out_valid, 1'b0);
    tick();
    check({nm, "_vld"}, out_valid, 1'b1);
    check({nm, "_res"}, out_result, exp);
    check({nm, "_tag"}, out_tag, 6'd5);
    tick();
  endtask

  // Bounded wait for the next result, compare, then consume it.
  task automatic expect_out(input string nm, input logic [31:0] exp_res, input logic [5:0] exp_tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_vld"}, out_valid, 1'b1);
    check({nm, "_res"}, out_result, exp_res);
    check({nm, "_tag"}, out_tag, exp_tag);
    tick();
  endtask

  logic [31:0] stall_res [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_func = M_MUL; in_rs1 = '0; in_rs2 = '0;
    in_tag = '0; in_bmask = '0; squash_valid = 1'b0; squash_bmask = '0;
    resolve_valid = 1'b0; resolve_bmask = '0; out_ready = 1'b1;
    stall_res[0] = 32'd2; stall_res[1] = 32'd12; stall_res[2] = 32'd30; stall_res[3] = 32'd56;

    // Reset state
    tick(); tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_result", out_result, 32'h0);
    check("rst_tag", out_tag, 6'h0);
    check("rst_bmask", out_bmask, 4'h0);

    // Arithmetic and latency
    run_one("mul_7x-3", M_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_one("mulh_min", M_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_one("mulhu_max", M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_one("mulhsu", M_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_one("mul_lo", M_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780);
    run_one("mulh_m1", M_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    // Stall: 4 back-to-back ops, output held for 6 cycles, then drained in order
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(M_MUL, 32'(2*k+1), 32'(2*k+2), 6'(k+1), 4'b0000);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("stall_vld", out_valid, 1'b1);
      check("stall_res", out_result, 32'd2);
      check("stall_tag", out_tag, 6'd1);
      check("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_vld", out_valid, 1'b1);
      check("drain_res", out_result, stall_res[k]);
      check("drain_tag", out_tag, 6'(k+1));
      tick();
    end
    check("drain_empty", out_valid, 1'b0);

    // Squash one of two in-flight entries by branch mask
    drive(M_MUL, 32'd2, 32'd3, 6'd10, 4'b0010);
    tick();
    drive(M_MUL, 32'd4, 32'd5, 6'd11, 4'b0100);
    tick();
    in_valid = 1'b0;
    squash_valid = 1'b1; squash_bmask = 4'b0010;
    tick();
    squash_valid = 1'b0; squash_bmask = 4'b0000;
    check("sq_busy", busy, 1'b1);
    tick();
    check("sq_gone", out_valid, 1'b0);
    tick();
    check("sq_keep_vld", out_valid, 1'b1);
    check("sq_keep_res", out_result, 32'd20);
    check("sq_keep_tag", out_tag, 6'd11);
    check("sq_keep_bmask", out_bmask, 4'b0100);
    tick();

    // Squash and resolve of the same bit together: squash wins
    drive(M_MUL, 32'd6, 32'd6, 6'd12, 4'b0100);
    tick();
    in_valid = 1'b0;
    squash_valid = 1'b1; squash_bmask = 4'b0100;
    resolve_valid = 1'b1; resolve_bmask = 4'b0100;
    tick();
    squash_valid = 1'b0; resolve_valid = 1'b0;
    check("sqres_busy", busy, 1'b0);
    tick(); tick(); tick();
    check("sqres_no_out", out_valid, 1'b0);

    // Resolve alone clears bit 2 of an in-flight op
    drive(M_MUL, 32'd3, 32'd3, 6'd13, 4'b0110);
    tick();
    in_valid = 1'b0;
    resolve_valid = 1'b1; resolve_bmask = 4'b0100;
    tick();
    resolve_valid = 1'b0;
    tick(); tick();
    check("res_vld", out_valid, 1'b1);
    check("res_bmask", out_bmask, 4'b0010);
    check("res_res", out_result, 32'd9);
    tick();

    // Combinational squash gating and resolve on a stalled output
    out_ready = 1'b0;
    drive(M_MUL, 32'd5, 32'd5, 6'd14, 4'b0100);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("comb_vld", out_valid, 1'b1);
    squash_valid = 1'b1; squash_bmask = 4'b0100;
    #1;
    check("comb_sq_gate", out_valid, 1'b0);
    squash_valid = 1'b0;
    #1;
    check("comb_sq_off", out_valid, 1'b1);
    resolve_valid = 1'b1; resolve_bmask = 4'b0100;
    #1;
    check("comb_res_bmask", out_bmask, 4'b0000);
    tick();
    resolve_valid = 1'b0;
    #1;
    check("held_res_bmask", out_bmask, 4'b0000);
    check("held_res", out_result, 32'd25);
    out_ready = 1'b1;
    tick();
    check("comb_drained", out_valid, 1'b0);

    // Reset mid-operation abandons in-flight ops
    drive(M_MUL, 32'd8, 32'd8, 6'd30, 4'b0000);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_tag", out_tag, 6'd0);
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_out", out_valid, 1'b0);
      tick();
    end

    // Bubble behaviour behind a stalled output
    out_ready = 1'b0;
    drive(M_MUL, 32'd2, 32'd2, 6'd20, 4'b0000);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    drive(M_MUL, 32'd3, 32'd5, 6'd21, 4'b0000);
    tick();
`ifdef MULT_PIPE_COLLAPSE_EN
    check("col_rdy_gap1", in_ready, 1'b1);
    drive(M_MUL, 32'd6, 32'd7, 6'd22, 4'b0000);
    tick();
    check("col_rdy_gap2", in_ready, 1'b1);
    drive(M_MUL, 32'd9, 32'd9, 6'd23, 4'b0000);
    tick();
    in_valid = 1'b0;
    check("col_rdy_full", in_ready, 1'b0);
    out_ready = 1'b1;
    expect_out("col_f", 32'd4, 6'd20);
    expect_out("col_g", 32'd15, 6'd21);
    expect_out("col_h", 32'd42, 6'd22);
    expect_out("col_i", 32'd81, 6'd23);
`else
    in_valid = 1'b0;
    check("frz_rdy", in_ready, 1'b0);
    out_ready = 1'b1;
    expect_out("frz_f", 32'd4, 6'd20);
    expect_out("frz_g", 32'd15, 6'd21);
`endif
    check("end_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
